// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, sequencer state type and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned AES_KW = 128;
  localparam int unsigned AES_RW = 4;

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} seq_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as v^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = v;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [AES_RW-1:0] n);
    logic [7:0] r;
    case (n)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/singleKeyExpansion.sv
// One AES-128 key expansion round, registered output; synchronous active-high reset.
module singleKeyExpansion
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [AES_RW-1:0]   keyNum,
  input  logic [AES_KW-1:0]   keyInput,
  output logic [AES_KW-1:0]   keyOutput
);

  logic [31:0] w0, w1, w2, w3, temp;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0 = keyInput[127:96];
    w1 = keyInput[95:64];
    w2 = keyInput[63:32];
    w3 = keyInput[31:0];
    // RotWord then SubWord, then round constant into the top byte.
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(keyNum), 24'h000000};
    n0 = w0 ^ temp;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keyOutput <= '0;
    end else if (enable) begin
      keyOutput <= {n0, n1, n2, n3};
    end
  end

endmodule

// File: rtl/key_schedule_sequencer.sv
// AES-128 key schedule sequencer: drives singleKeyExpansion for rounds 1..10 into an 11-entry store.
// Optional KEYSCHED_REV_READ_EN adds rd_rev for descending round-key reads.
module key_schedule_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR,
  parameter int unsigned KW = AES_KW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [KW-1:0]     key_in,
  input  logic [3:0]        rd_addr,
`ifdef KEYSCHED_REV_READ_EN
  input  logic              rd_rev,
`endif
  output logic [KW-1:0]     rd_key,
  output logic              busy,
  output logic              done,
  output logic              key_valid
);

  localparam logic [AES_RW-1:0] LastRound = AES_RW'(NR);

  seq_state_e          state;
  logic [AES_RW-1:0]   round;
  logic [KW-1:0]       store [0:NR];
  logic [KW-1:0]       key_out;
  logic [KW-1:0]       key_input;
  logic [AES_RW-1:0]   idx;

  // Round 1 seeds from the stored cipher key; later rounds feed back the registered output.
  assign key_input = (round == 4'd1) ? store[0] : key_out;

  singleKeyExpansion u_expand (
    .clk       (clk),
    .reset     (~reset),
    .enable    (state == EXPAND),
    .keyNum    (round),
    .keyInput  (key_input),
    .keyOutput (key_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      round     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      for (int i = 0; i <= int'(NR); i++) store[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            store[0]  <= key_in;
            round     <= 4'd1;
            busy      <= 1'b1;
            key_valid <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          if (round >= 4'd2) store[round - 4'd1] <= key_out;
          if (round == LastRound) state <= FINISH;
          else round <= round + 4'd1;
        end
        FINISH: begin
          store[NR] <= key_out;
          done      <= 1'b1;
          key_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_key = '0;
    idx    = rd_addr;
`ifdef KEYSCHED_REV_READ_EN
    if (rd_rev) idx = LastRound - rd_addr;
`endif
    if (rd_addr <= LastRound) rd_key = store[idx];
  end

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Self-checking bench for key_schedule_sequencer against a word-oriented FIPS-197 key schedule model.
module tb_key_schedule_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic         busy, done, key_valid;
`ifdef KEYSCHED_REV_READ_EN
  logic         rd_rev;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:10];

  key_schedule_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_in    (key_in),
    .rd_addr   (rd_addr),
`ifdef KEYSCHED_REV_READ_EN
    .rd_rev    (rd_rev),
`endif
    .rd_key    (rd_key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box table from the generator walk over GF(2^8) (multiply by 3 / divide by 3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_read(input string tag, input int addr, input logic [127:0] exp);
    rd_addr = 4'(addr);
    #1;
    check($sformatf("%s[%0d]", tag, addr), rd_key, exp);
  endtask

  task automatic check_store(input string tag);
    for (int a = 0; a < 16; a++) check_read(tag, a, (a <= 10) ? exp_rk[a] : 128'h0);
  endtask

  task automatic do_start(input logic [127:0] key);
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = rand128();
  endtask

  // Counts negedges after the accepting edge until done; 0 means it never arrived.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("done_timeout", 128'(done), 128'h1);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [127:0] k;
    build_sbox();
    start   = 1'b0;
    key_in  = '0;
    rd_addr = '0;
`ifdef KEYSCHED_REV_READ_EN
    rd_rev  = 1'b0;
`endif
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_done", 128'(done), 128'h0);
    check("rst_valid", 128'(key_valid), 128'h0);
    for (int a = 0; a < 16; a += 5) check_read("rst_rd", a, 128'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // FIPS-197 key: latency, busy window and known round keys.
    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model(k);
    do_start(k);
    @(negedge clk);
    check("fips_busy_early", 128'(busy), 128'h1);
    check("fips_valid_early", 128'(key_valid), 128'h0);
    cyc = 1;
    for (int i = 2; i <= 40 && !done; i++) begin
      @(negedge clk);
      cyc = i;
    end
    check("fips_done_latency", 128'(cyc), 128'd12);
    check("fips_busy_at_done", 128'(busy), 128'h0);
    check("fips_valid", 128'(key_valid), 128'h1);
    @(negedge clk);
    check("fips_done_one_pulse", 128'(done), 128'h0);
    check_read("fips_rk1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
    check_read("fips_rk10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_read("fips_rk0", 0, k);
    check_read("fips_oob", 15, 128'h0);
    check_store("fips");

    // Start while busy is ignored.
    k = rand128();
    model(k);
    do_start(k);
    repeat (4) @(negedge clk);
    start = 1'b1;
    key_in = 128'h0;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("busy_start_pulses", 128'(pulses), 128'd1);
    check_store("busy_start");

    // Asynchronous reset mid-expansion.
    do_start(rand128());
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'h0);
    check("mid_rst_valid", 128'(key_valid), 128'h0);
    check("mid_rst_done", 128'(done), 128'h0);
    for (int a = 0; a <= 10; a++) check_read("mid_rst_rd", a, 128'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("mid_rst_no_done", 128'(pulses), 128'd0);
    reset = 1'b1;
    k = rand128();
    model(k);
    do_start(k);
    wait_done(cyc);
    check("after_rst_latency", 128'(cyc), 128'd12);
    check_store("after_rst");

    // Back-to-back start on the done cycle.
    do_start(rand128());
    wait_done(cyc);
    k = 128'h000102030405060708090a0b0c0d0e0f;
    model(k);
    start  = 1'b1;
    key_in = k;
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_valid_drop", 128'(key_valid), 128'h0);
    check("b2b_busy", 128'(busy), 128'h1);
    wait_done(cyc);
    check("b2b_latency", 128'(cyc), 128'd12);
    check_read("b2b_rk10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_store("b2b");

    // Random keys.
    for (int n = 0; n < 3; n++) begin
      k = rand128();
      model(k);
      do_start(k);
      wait_done(cyc);
      check("rnd_latency", 128'(cyc), 128'd12);
      for (int j = 0; j < 6; j++) begin
        int a;
        a = int'($urandom_range(0, 15));
        check_read("rnd_rd", a, (a <= 10) ? exp_rk[a] : 128'h0);
      end
    end

`ifdef KEYSCHED_REV_READ_EN
    rd_rev = 1'b1;
    check_read("rev_rd0", 0, exp_rk[10]);
    check_read("rev_rd3", 3, exp_rk[7]);
    check_read("rev_rd10", 10, exp_rk[0]);
    check_read("rev_oob", 12, 128'h0);
    rd_rev = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_schedule_sequencer.md
Name: key_schedule_sequencer

Overview:
- Sequences the full AES-128 key schedule around the existing single-round key expansion block.
- Loads a cipher key, iterates the expansion step for rounds 1..10, and stores round keys 0..10.
- Presents a random-access round-key read port to the cipher/decipher round datapath.
- Sits between the key source (host/register interface) and the round datapath.

Parameters:
- NR, 10, number of expansion rounds; fixed for AES-128, other values unsupported.
- KW, 128, key/round-key width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to expand key_in; ignored while busy.
- key_in  in  128  cipher key, sampled on the start edge only.
- rd_addr  in  4  round-key index 0..10.
- rd_key  out  128  combinational read of store[rd_addr]; 0 for rd_addr > 10.
- busy  out  1  high while expansion is in progress.
- done  out  1  one-cycle pulse when round key 10 is written.
- key_valid  out  1  high when all 11 stored keys belong to the last accepted key.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - store[0..10], round counter, busy, done and key_valid all clear to 0.
  - The expansion sub-module is held in reset (its reset input = ~reset).
- States: IDLE, EXPAND, FINISH.
- IDLE:
  - start=1 at edge E0 writes key_in into store[0].
  - Sets round=1, busy=1 and key_valid=0, then moves to EXPAND.
- EXPAND, one round per cycle:
  - The sub-module enable is high throughout.
  - Sub-module keyNum = round.
  - Sub-module keyInput = store[0] when round==1, else the sub-module's own registered keyOutput (feedback path).
  - Each edge writes the sub-module's keyOutput into store[round-1] when round>=2; round then increments.
  - After the edge that latches round 10, move to FINISH.
- FINISH (single cycle):
  - Writes keyOutput into store[10].
  - Pulses done=1, sets key_valid=1, clears busy and returns to IDLE.
- Timing from start at E0:
  - store[k] is written at edge E0+k+1 for k=1..10.
  - done is high during the cycle after E0+11.
  - busy is high for 11 cycles (E0 through E0+11).
- start while busy=1: ignored, with no restart and no queueing.
- start in the same cycle done is high: accepted (state is IDLE); key_valid drops at that edge.
- rd_addr during expansion:
  - rd_key returns current store contents; these may be a mix of old and new keys.
  - key_valid=0 flags this condition.
  - Consumers must not use rd_key while key_valid=0.
- Reset mid-expansion: immediate abort; all storage cleared; no done pulse.
- Arithmetic: all XOR/S-box work is in the sub-module; this block adds only the 4-bit counter (1..10) and address decode.

Optional Feature:
- Macro: KEYSCHED_REV_READ_EN.
- Defined:
  - Adds input rd_rev (1 bit).
  - When rd_rev=1, rd_key = store[10-rd_addr], so decryption reads round keys in reverse order with an ascending address.
  - rd_addr > 10 still returns 0.
- Undefined: the port is absent and rd_key = store[rd_addr] only.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR=10 and AES_KW=128.
  - The round-index width (4).
  - The sequencer state enum {IDLE, EXPAND, FINISH}.
- Sub-module: one instance of singleKeyExpansion.
  - Reused unmodified.
  - Its synchronous active-high reset is driven by ~reset.
  - Its enable is driven by (state==EXPAND).
- The round-key storage is an 11x128 register array in this block; no separate module.

Test Plan:
- FIPS-197 key, round 1 and done timing:
  - Stimulus: after reset, start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - Response: done pulses exactly 12 cycles after start; rd_addr=1 gives a0fafe1788542cb123a339392a6c7605.
- FIPS-197 key, last round:
  - Stimulus: same key as above, read rd_addr=10.
  - Response: rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6; rd_addr=0 returns key_in; rd_addr=15 returns 0.
- Start while busy:
  - Stimulus: second start with key 000…0 at cycle 5 of expansion.
  - Response: ignored; results equal the first key's schedule; exactly one done pulse.
- Reset mid-expansion:
  - Stimulus: assert reset at cycle 6.
  - Response: busy, key_valid, done and all rd_key reads are 0 immediately (asynchronously); a new start then completes normally.
- Back-to-back starts:
  - Stimulus: start on the done cycle with key 000102…0f.
  - Response: key_valid drops at that edge; round 10 key = 13111d7fe3944a17f307a78b4d2b30c5.
- Reverse read (KEYSCHED_REV_READ_EN defined):
  - Stimulus: rd_rev=1, rd_addr=0.
  - Response: rd_key returns the round-10 key.
